// File: rtl/ff_pkg.sv
// Shared definitions for the multimode flip-flop register: mode encodings
// and the per-bit next-state function used by every cell.
package ff_pkg;

  localparam logic [1:0] MODE_SR = 2'd0;
  localparam logic [1:0] MODE_JK = 2'd1;
  localparam logic [1:0] MODE_D  = 2'd2;
  localparam logic [1:0] MODE_T  = 2'd3;

  // Next state of one bit given its type, its two inputs and current state.
  // SR with S=R=1 holds; the caller flags that case separately.
  function automatic logic ff_next(input logic [1:0] mode,
                                   input logic       s,
                                   input logic       c,
                                   input logic       q);
    logic n;
    n = q;
    case (mode)
      MODE_SR: begin
        case ({s, c})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          default: n = q;
        endcase
      end
      MODE_JK: begin
        case ({s, c})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          2'b11:   n = ~q;
          default: n = q;
        endcase
      end
      MODE_D:  n = s;
      MODE_T:  n = s ? ~q : q;
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mode_ff_cell.sv
// One bit of the multimode register: an edge-triggered flip-flop whose
// type is selected by mode, with a registered complement output and a
// combinational flag for the SR S=R=1 condition at the current edge.
module mode_ff_cell
  import ff_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enabled,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       c,
  output logic       q,
  output logic       qn,
  output logic       forb
);

  logic q_q, q_d;
  logic qn_q;

  // Next state: hold when disabled, otherwise apply the selected FF type.
  always_comb begin
    q_d = q_q;
    if (enabled) begin
      q_d = ff_next(mode, s, c, q_q);
    end
  end

  // State and complement registered together so qn is never equal to q.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q  <= 1'b0;
      qn_q <= 1'b1;
    end else begin
      q_q  <= q_d;
      qn_q <= ~q_d;
    end
  end

  assign q    = q_q;
  assign qn   = qn_q;
  assign forb = enabled & (mode == MODE_SR) & s & c;

endmodule

// File: rtl/multimode_ff_register.sv
// WIDTH-bit register of run-time selectable flip-flops (SR/JK/D/T) with
// forbidden-input reporting: per-edge mask and pulse, sticky flag and a
// saturating event counter.
module multimode_ff_register
  import ff_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enabled,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     set,
  input  logic [WIDTH-1:0]     clear,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     notQ,
  output logic                 forbidden,
  output logic [WIDTH-1:0]     forbidden_mask,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     forb_vec;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic                 forbidden_q, forbidden_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] count_q, count_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mode_ff_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .enabled (enabled),
      .mode    (mode),
      .s       (set[i]),
      .c       (clear[i]),
      .q       (Q[i]),
      .qn      (notQ[i]),
      .forb    (forb_vec[i])
    );
  end

  // Error bookkeeping; a new forbidden event takes priority over clr_err.
  always_comb begin
    mask_d      = forb_vec;
    forbidden_d = |forb_vec;
    sticky_d    = sticky_q;
    count_d     = count_q;
    if (forbidden_d) begin
      sticky_d = 1'b1;
      if (clr_err) begin
        count_d = ERR_CNT_W'(1);
      end else if (count_q != CNT_MAX) begin
        count_d = count_q + ERR_CNT_W'(1);
      end
    end else if (clr_err) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  // Error state registers, cleared by reset ahead of everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q      <= '0;
      forbidden_q <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      mask_q      <= mask_d;
      forbidden_q <= forbidden_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign forbidden_mask = mask_q;
  assign forbidden      = forbidden_q;
  assign err_sticky     = sticky_q;
  assign err_count      = count_q;

endmodule
